// File: rtl/probe_level_counter_if.sv
// rtl/probe_level_counter_if.sv - latched measurement results and ready/ack handshake
interface probe_level_counter_if #(
  parameter int COUNTER_WIDTH = 24
);
  logic [COUNTER_WIDTH-1:0] high_count;
  logic [COUNTER_WIDTH-1:0] low_count;
  logic [COUNTER_WIDTH-1:0] z_count;
  logic [COUNTER_WIDTH-1:0] edge_count;
  logic                     ready;
  logic                     overrun;
  logic                     ack;

  modport master (
    output high_count, low_count, z_count, edge_count, ready, overrun,
    input  ack
  );

  modport slave (
    input  high_count, low_count, z_count, edge_count, ready, overrun,
    output ack
  );
endinterface

// File: rtl/probe_level_counter.sv
// rtl/probe_level_counter.sv - classifies synchronized comparator samples as HIGH/LOW/Z
// and counts levels and rising edges over a fixed window, latching results for firmware.
module probe_level_counter #(
  parameter int TIME_PERIOD   = 5000,
  parameter int COUNTER_WIDTH = 24
) (
  input  logic                  clk,
  input  logic                  nreset,
  input  logic                  comp_out_hi,
  input  logic                  comp_out_lo,
  input  logic                  enable,
  probe_level_counter_if.master res
);

  localparam int WIN_W = (TIME_PERIOD > 1) ? $clog2(TIME_PERIOD) : 1;
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(TIME_PERIOD - 1);

  typedef enum logic [1:0] {
    LVL_NONE,
    LVL_LOW,
    LVL_HIGH
  } level_e;

  logic hi_s1_q, hi_s1_d, hi_s2_q, hi_s2_d;
  logic lo_s1_q, lo_s1_d, lo_s2_q, lo_s2_d;
  logic [WIN_W-1:0] win_q, win_d;
  level_e lvl_q, lvl_d;
  logic [COUNTER_WIDTH-1:0] high_acc_q, high_acc_d;
  logic [COUNTER_WIDTH-1:0] low_acc_q, low_acc_d;
  logic [COUNTER_WIDTH-1:0] z_acc_q, z_acc_d;
  logic [COUNTER_WIDTH-1:0] edge_acc_q, edge_acc_d;
  logic [COUNTER_WIDTH-1:0] high_out_q, high_out_d;
  logic [COUNTER_WIDTH-1:0] low_out_q, low_out_d;
  logic [COUNTER_WIDTH-1:0] z_out_q, z_out_d;
  logic [COUNTER_WIDTH-1:0] edge_out_q, edge_out_d;
  logic ready_q, ready_d;
  logic overrun_q, overrun_d;
  logic en_q, en_d;

  logic is_hi, is_lo, is_z, edge_hit, end_cycle;
  logic [COUNTER_WIDTH-1:0] high_sum, low_sum, z_sum, edge_sum;

  // Saturating +1 keeps a misconfigured window from wrapping counts back to small values.
  function automatic logic [COUNTER_WIDTH-1:0] sat_inc(input logic [COUNTER_WIDTH-1:0] v,
                                                       input logic inc);
    return (inc && (v != '1)) ? v + COUNTER_WIDTH'(1) : v;
  endfunction

  always_comb begin
    is_hi     = hi_s2_q;
    is_lo     = !hi_s2_q && lo_s2_q;
    is_z      = !hi_s2_q && !lo_s2_q;
    // Z samples never update lvl_q, so LOW-Z-HIGH still registers as an edge.
    edge_hit  = (lvl_q == LVL_LOW) && is_hi;
    end_cycle = enable && (win_q == WIN_LAST);

    high_sum = sat_inc(high_acc_q, is_hi);
    low_sum  = sat_inc(low_acc_q, is_lo);
    z_sum    = sat_inc(z_acc_q, is_z);
    edge_sum = sat_inc(edge_acc_q, edge_hit);

    hi_s1_d    = comp_out_hi;
    hi_s2_d    = hi_s1_q;
    lo_s1_d    = comp_out_lo;
    lo_s2_d    = lo_s1_q;
    win_d      = win_q;
    lvl_d      = lvl_q;
    high_acc_d = high_acc_q;
    low_acc_d  = low_acc_q;
    z_acc_d    = z_acc_q;
    edge_acc_d = edge_acc_q;
    high_out_d = high_out_q;
    low_out_d  = low_out_q;
    z_out_d    = z_out_q;
    edge_out_d = edge_out_q;
    ready_d    = ready_q;
    overrun_d  = overrun_q;
    en_d       = enable;

    if (!enable) begin
      win_d      = '0;
      lvl_d      = LVL_NONE;
      high_acc_d = '0;
      low_acc_d  = '0;
      z_acc_d    = '0;
      edge_acc_d = '0;
    end else begin
      if (is_hi) begin
        lvl_d = LVL_HIGH;
      end else if (is_lo) begin
        lvl_d = LVL_LOW;
      end

      if (end_cycle) begin
        win_d      = '0;
        high_acc_d = '0;
        low_acc_d  = '0;
        z_acc_d    = '0;
        edge_acc_d = '0;
        high_out_d = high_sum;
        low_out_d  = low_sum;
        z_out_d    = z_sum;
        edge_out_d = edge_sum;
      end else begin
        win_d      = win_q + WIN_W'(1);
        high_acc_d = high_sum;
        low_acc_d  = low_sum;
        z_acc_d    = z_sum;
        edge_acc_d = edge_sum;
      end
    end

    // A fresh latch outranks a coincident ack.
    if (end_cycle) begin
      ready_d = 1'b1;
    end else if (res.ack) begin
      ready_d = 1'b0;
    end

    if (end_cycle && ready_q && !res.ack) begin
      overrun_d = 1'b1;
    end else if (en_q && !enable) begin
      overrun_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      hi_s1_q    <= 1'b0;
      hi_s2_q    <= 1'b0;
      lo_s1_q    <= 1'b0;
      lo_s2_q    <= 1'b0;
      win_q      <= '0;
      lvl_q      <= LVL_NONE;
      high_acc_q <= '0;
      low_acc_q  <= '0;
      z_acc_q    <= '0;
      edge_acc_q <= '0;
      high_out_q <= '0;
      low_out_q  <= '0;
      z_out_q    <= '0;
      edge_out_q <= '0;
      ready_q    <= 1'b0;
      overrun_q  <= 1'b0;
      en_q       <= 1'b0;
    end else begin
      hi_s1_q    <= hi_s1_d;
      hi_s2_q    <= hi_s2_d;
      lo_s1_q    <= lo_s1_d;
      lo_s2_q    <= lo_s2_d;
      win_q      <= win_d;
      lvl_q      <= lvl_d;
      high_acc_q <= high_acc_d;
      low_acc_q  <= low_acc_d;
      z_acc_q    <= z_acc_d;
      edge_acc_q <= edge_acc_d;
      high_out_q <= high_out_d;
      low_out_q  <= low_out_d;
      z_out_q    <= z_out_d;
      edge_out_q <= edge_out_d;
      ready_q    <= ready_d;
      overrun_q  <= overrun_d;
      en_q       <= en_d;
    end
  end

  assign res.high_count = high_out_q;
  assign res.low_count  = low_out_q;
  assign res.z_count    = z_out_q;
  assign res.edge_count = edge_out_q;
  assign res.ready      = ready_q;
  assign res.overrun    = overrun_q;

endmodule

// File: tb/tb_probe_level_counter.sv
// tb/tb_probe_level_counter.sv - directed checks of window counts, handshake and reset
module tb_probe_level_counter;

  logic clk;
  logic nreset;
  logic comp_out_hi;
  logic comp_out_lo;
  logic enable;
  int   tests;
  int   fails;
  int   mode;
  int   pcnt;
  bit   ok;
  int   sum;

  probe_level_counter_if #(.COUNTER_WIDTH(16)) res_if ();

  probe_level_counter #(
    .TIME_PERIOD   (100),
    .COUNTER_WIDTH (16)
  ) dut (
    .clk         (clk),
    .nreset      (nreset),
    .comp_out_hi (comp_out_hi),
    .comp_out_lo (comp_out_lo),
    .enable      (enable),
    .res         (res_if.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // mode 1: 5 high / 5 low square wave; mode 2: LOW(3) Z(4) HIGH(3)
  task automatic step();
    int ph;
    @(negedge clk);
    pcnt++;
    ph = pcnt % 10;
    case (mode)
      1: begin comp_out_hi = (ph < 5); comp_out_lo = !(ph < 5); end
      2: begin comp_out_lo = (ph < 3); comp_out_hi = (ph >= 7); end
      default: ;
    endcase
  endtask

  task automatic do_reset();
    nreset = 1'b0;
    repeat (3) @(negedge clk);
    nreset = 1'b1;
  endtask

  task automatic wait_ready(output bit found);
    found = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (res_if.ready) begin
        found = 1'b1;
        break;
      end
      step();
    end
  endtask

  task automatic ack_pulse();
    res_if.ack = 1'b1;
    step();
    res_if.ack = 1'b0;
  endtask

  task automatic test_reset();
    mode = 0; comp_out_hi = 0; comp_out_lo = 0; enable = 1;
    nreset = 1'b0;
    repeat (3) @(negedge clk);
    tests++;
    if ({res_if.high_count, res_if.low_count, res_if.z_count, res_if.edge_count,
         res_if.ready, res_if.overrun} !== 66'd0) begin
      fails++;
      $display("FAIL reset_outputs got h=%0d l=%0d z=%0d e=%0d r=%0b o=%0b exp all 0",
               res_if.high_count, res_if.low_count, res_if.z_count, res_if.edge_count,
               res_if.ready, res_if.overrun);
    end
    nreset = 1'b1;
    repeat (99) step();
    tests++;
    if (res_if.ready !== 1'b0 || res_if.z_count !== 16'd0) begin
      fails++;
      $display("FAIL reset_early got ready=%0b z=%0d exp ready=0 z=0", res_if.ready, res_if.z_count);
    end
    step();
    tests++;
    if (res_if.ready !== 1'b1 || res_if.z_count !== 16'd100) begin
      fails++;
      $display("FAIL reset_first_latch got ready=%0b z=%0d exp ready=1 z=100",
               res_if.ready, res_if.z_count);
    end
    tests++;
    if (res_if.high_count !== 16'd0 || res_if.low_count !== 16'd0 ||
        res_if.edge_count !== 16'd0 || res_if.overrun !== 1'b0) begin
      fails++;
      $display("FAIL reset_first_other got h=%0d l=%0d e=%0d o=%0b exp 0 0 0 0",
               res_if.high_count, res_if.low_count, res_if.edge_count, res_if.overrun);
    end
    ack_pulse();
    tests++;
    if (res_if.ready !== 1'b0) begin
      fails++;
      $display("FAIL reset_ack got ready=%0b exp 0", res_if.ready);
    end
  endtask

  task automatic test_high_hold();
    mode = 0; comp_out_hi = 1; comp_out_lo = 0; enable = 1;
    do_reset();
    repeat (100) step();
    tests++;
    if (res_if.high_count !== 16'd98 || res_if.z_count !== 16'd2 ||
        res_if.low_count !== 16'd0 || res_if.edge_count !== 16'd0) begin
      fails++;
      $display("FAIL high_win1 got h=%0d l=%0d z=%0d e=%0d exp 98 0 2 0",
               res_if.high_count, res_if.low_count, res_if.z_count, res_if.edge_count);
    end
    ack_pulse();
    wait_ready(ok);
    tests++;
    if (!ok || res_if.high_count !== 16'd100 || res_if.z_count !== 16'd0 ||
        res_if.edge_count !== 16'd0) begin
      fails++;
      $display("FAIL high_win2 got ok=%0b h=%0d z=%0d e=%0d exp 1 100 0 0",
               ok, res_if.high_count, res_if.z_count, res_if.edge_count);
    end
    ack_pulse();
  endtask

  task automatic test_square();
    mode = 1; pcnt = 0; enable = 1;
    do_reset();
    wait_ready(ok);
    ack_pulse();
    for (int w = 0; w < 2; w++) begin
      wait_ready(ok);
      tests++;
      if (!ok || res_if.high_count !== 16'd50 || res_if.low_count !== 16'd50 ||
          res_if.z_count !== 16'd0 || res_if.edge_count !== 16'd10) begin
        fails++;
        $display("FAIL square_win%0d got ok=%0b h=%0d l=%0d z=%0d e=%0d exp 1 50 50 0 10",
                 w, ok, res_if.high_count, res_if.low_count, res_if.z_count, res_if.edge_count);
      end
      ack_pulse();
    end
  endtask

  task automatic test_lzh_pattern();
    mode = 2; pcnt = 0; enable = 1;
    do_reset();
    wait_ready(ok);
    ack_pulse();
    for (int w = 0; w < 2; w++) begin
      wait_ready(ok);
      tests++;
      if (!ok || res_if.high_count !== 16'd30 || res_if.low_count !== 16'd30 ||
          res_if.z_count !== 16'd40 || res_if.edge_count !== 16'd10) begin
        fails++;
        $display("FAIL lzh_win%0d got ok=%0b h=%0d l=%0d z=%0d e=%0d exp 1 30 30 40 10",
                 w, ok, res_if.high_count, res_if.low_count, res_if.z_count, res_if.edge_count);
      end
      ack_pulse();
    end
    mode = 0;
  endtask

  task automatic test_overrun();
    mode = 0; comp_out_hi = 0; comp_out_lo = 0; enable = 1;
    do_reset();
    repeat (100) step();
    tests++;
    if (res_if.ready !== 1'b1 || res_if.overrun !== 1'b0) begin
      fails++;
      $display("FAIL ovr_first got ready=%0b ovr=%0b exp 1 0", res_if.ready, res_if.overrun);
    end
    repeat (100) step();
    tests++;
    if (res_if.ready !== 1'b1 || res_if.overrun !== 1'b1) begin
      fails++;
      $display("FAIL ovr_set got ready=%0b ovr=%0b exp 1 1", res_if.ready, res_if.overrun);
    end
    repeat (99) step();
    res_if.ack = 1'b1;
    step();
    res_if.ack = 1'b0;
    tests++;
    if (res_if.ready !== 1'b1) begin
      fails++;
      $display("FAIL ack_on_end got ready=%0b exp 1", res_if.ready);
    end
    ack_pulse();
    tests++;
    if (res_if.ready !== 1'b0 || res_if.overrun !== 1'b1) begin
      fails++;
      $display("FAIL ack_late got ready=%0b ovr=%0b exp 0 1", res_if.ready, res_if.overrun);
    end
    ack_pulse();
    tests++;
    if (res_if.ready !== 1'b0 || res_if.z_count !== 16'd100) begin
      fails++;
      $display("FAIL ack_idle got ready=%0b z=%0d exp 0 100", res_if.ready, res_if.z_count);
    end
    enable = 1'b0;
    step();
    tests++;
    if (res_if.overrun !== 1'b0 || res_if.z_count !== 16'd100) begin
      fails++;
      $display("FAIL disable got ovr=%0b z=%0d exp 0 100", res_if.overrun, res_if.z_count);
    end
    repeat (5) step();
    enable = 1'b1;
    repeat (99) step();
    tests++;
    if (res_if.ready !== 1'b0) begin
      fails++;
      $display("FAIL reenable_early got ready=%0b exp 0", res_if.ready);
    end
    step();
    tests++;
    if (res_if.ready !== 1'b1 || res_if.z_count !== 16'd100) begin
      fails++;
      $display("FAIL reenable_latch got ready=%0b z=%0d exp 1 100", res_if.ready, res_if.z_count);
    end
    ack_pulse();
  endtask

  task automatic test_mid_reset();
    mode = 0; comp_out_hi = 1; comp_out_lo = 0; enable = 1;
    do_reset();
    repeat (150) step();
    nreset = 1'b0;
    #1;
    tests++;
    if (res_if.high_count !== 16'd0 || res_if.ready !== 1'b0 || res_if.overrun !== 1'b0) begin
      fails++;
      $display("FAIL midreset_clear got h=%0d ready=%0b ovr=%0b exp 0 0 0",
               res_if.high_count, res_if.ready, res_if.overrun);
    end
    repeat (2) @(negedge clk);
    nreset = 1'b1;
    repeat (99) step();
    tests++;
    if (res_if.ready !== 1'b0) begin
      fails++;
      $display("FAIL midreset_early got ready=%0b exp 0", res_if.ready);
    end
    step();
    sum = int'(res_if.high_count) + int'(res_if.low_count) + int'(res_if.z_count);
    tests++;
    if (res_if.ready !== 1'b1 || sum != 100 || res_if.high_count !== 16'd98) begin
      fails++;
      $display("FAIL midreset_latch got ready=%0b sum=%0d h=%0d exp 1 100 98",
               res_if.ready, sum, res_if.high_count);
    end
    ack_pulse();
  endtask

  initial begin
    tests = 0; fails = 0; mode = 0; pcnt = 0;
    nreset = 1'b0; enable = 1'b1; comp_out_hi = 1'b0; comp_out_lo = 1'b0;
    res_if.ack = 1'b0;
    test_reset();
    test_high_hold();
    test_square();
    test_lzh_pattern();
    test_overrun();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
